// File: rtl/mem_bus_if.sv
// Memory bus interface stage: latches the address from abl/abh, runs a 4-phase
// req/ack handshake for one-byte reads and writes, and returns read data onto db.
module mem_bus_if #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  abl,
    input  logic [7:0]  abh,
    input  logic        adl_load,
    input  logic        adh_load,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        db_mem,
    input  logic        err_clr,
    inout  wire  [7:0]  db,
    output logic        busy,
    output logic        err,
    output logic [15:0] addr,
    output logic [7:0]  mdo,
    input  logic [7:0]  mdi,
    output logic        m_req,
    output logic        m_we,
    input  logic        m_ack
);

    // Handshake: m_req rises with m_we stable; memory raises m_ack once the
    // access is done; m_req then drops and the stage waits for m_ack to fall.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t             state_q, state_d;
    logic [15:0]        ar_q, ar_d;
    logic [7:0]         dr_q, dr_d;
    logic [7:0]         wdr_q, wdr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               m_req_q, m_req_d;
    logic               m_we_q, m_we_d;
    logic               err_q, err_d;
    logic               err_set;

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        dr_d    = dr_q;
        wdr_d   = wdr_q;
        cnt_d   = cnt_q;
        m_req_d = m_req_q;
        m_we_d  = m_we_q;
        err_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (adl_load) ar_d[7:0]  = abl;
                if (adh_load) ar_d[15:8] = abh;
                if (mem_rd && mem_wr) begin
                    err_set = 1'b1;
                end else if (mem_rd) begin
                    state_d = REQ;
                    m_req_d = 1'b1;
                    m_we_d  = 1'b0;
                    cnt_d   = '0;
                end else if (mem_wr) begin
                    wdr_d   = db;
                    state_d = REQ;
                    m_req_d = 1'b1;
                    m_we_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (m_ack) begin
                    if (!m_we_q) dr_d = mdi;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = DONE;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Abort after TIMEOUT cycles in REQ without an acknowledge.
                    if (cnt_q == CNT_LAST) begin
                        if (!m_we_q) dr_d = 8'hFF;
                        m_req_d = 1'b0;
                        m_we_d  = 1'b0;
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (!m_ack) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
                m_we_d  = 1'b0;
            end
        endcase

        // A fresh error event outranks a clear in the same cycle.
        if (err_set)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ar_q    <= '0;
            dr_q    <= '0;
            wdr_q   <= '0;
            cnt_q   <= '0;
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            dr_q    <= dr_d;
            wdr_q   <= wdr_d;
            cnt_q   <= cnt_d;
            m_req_q <= m_req_d;
            m_we_q  <= m_we_d;
            err_q   <= err_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign err   = err_q;
    assign addr  = ar_q;
    assign mdo   = wdr_q;
    assign m_req = m_req_q;
    assign m_we  = m_we_q;

    // Data register only reaches the shared bus while the stage is idle.
    assign db = (db_mem && (state_q == IDLE)) ? dr_q : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if with a 4-cycle timeout; db is pulled low when
// nobody drives it, so an undriven bus reads as 00.
module tb_mem_bus_if;

    logic        clk;
    logic        rst;
    logic [7:0]  abl, abh;
    logic        adl_load, adh_load;
    logic        mem_rd, mem_wr, db_mem, err_clr;
    tri0  [7:0]  db;
    logic        busy, err;
    logic [15:0] addr;
    logic [7:0]  mdo;
    logic [7:0]  mdi;
    logic        m_req, m_we, m_ack;
    logic [7:0]  tb_db;
    logic        tb_db_en;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];

    assign db = tb_db_en ? tb_db : 8'bzzzz_zzzz;

    mem_bus_if #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .abl(abl), .abh(abh),
        .adl_load(adl_load), .adh_load(adh_load),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .db_mem(db_mem), .err_clr(err_clr),
        .db(db), .busy(busy), .err(err), .addr(addr), .mdo(mdo), .mdi(mdi),
        .m_req(m_req), .m_we(m_we), .m_ack(m_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ar(input logic [15:0] a);
        abh = a[15:8]; abl = a[7:0];
        adh_load = 1'b1; adl_load = 1'b1;
        tick();
        adh_load = 1'b0; adl_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        vec_cnt++;
        if (addr !== 16'h0000 || busy !== 1'b0 || err !== 1'b0 || m_req !== 1'b0 ||
            m_we !== 1'b0 || mdo !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_state: addr=%h busy=%b err=%b m_req=%b m_we=%b mdo=%h, need 0000 0 0 0 0 00",
                     addr, busy, err, m_req, m_we, mdo);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_addr_read();
        int busy_cycles = 0;
        abh = 8'h12; adh_load = 1'b1;
        tick();
        adh_load = 1'b0;
        abl = 8'h34; adl_load = 1'b1;
        tick();
        adl_load = 1'b0;
        vec_cnt++;
        if (addr !== 16'h1234) begin
            err_cnt++;
            $display("FAIL addr_latch: addr=%h need 1234", addr);
        end
        exp_q.push_back(8'hA5);
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        if (busy) busy_cycles++;
        vec_cnt++;
        if (m_req !== 1'b1 || m_we !== 1'b0 || addr !== 16'h1234) begin
            err_cnt++;
            $display("FAIL read_req: m_req=%b m_we=%b addr=%h need 1 0 1234", m_req, m_we, addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (busy) busy_cycles++;
        end
        vec_cnt++;
        if (m_req !== 1'b1) begin
            err_cnt++;
            $display("FAIL read_wait: m_req=%b need 1", m_req);
        end
        m_ack = 1'b1; mdi = 8'hA5;
        tick();
        if (busy) busy_cycles++;
        vec_cnt++;
        if (m_req !== 1'b0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL read_ack: m_req=%b busy=%b need 0 1", m_req, busy);
        end
        tick();
        if (busy) busy_cycles++;
        m_ack = 1'b0; mdi = 8'h00;
        tick();
        if (busy) busy_cycles++;
        vec_cnt++;
        if (busy_cycles != 5 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL read_busy_len: cycles=%0d busy=%b need 5 0", busy_cycles, busy);
        end
        db_mem = 1'b1;
        #1;
        vec_cnt++;
        if (db !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL read_db: db=%h need %h", db, exp_q[0]);
        end
        void'(exp_q.pop_front());
        db_mem = 1'b0;
    endtask

    task automatic test_write();
        load_ar(16'h80FF);
        tb_db = 8'h3C; tb_db_en = 1'b1; mem_wr = 1'b1;
        tick();
        tb_db_en = 1'b0; mem_wr = 1'b0;
        db_mem = 1'b1;
        #1;
        vec_cnt++;
        if (m_req !== 1'b1 || m_we !== 1'b1 || mdo !== 8'h3C || addr !== 16'h80FF || db !== 8'h00) begin
            err_cnt++;
            $display("FAIL write_req: m_req=%b m_we=%b mdo=%h addr=%h db=%h need 1 1 3c 80ff 00",
                     m_req, m_we, mdo, addr, db);
        end
        m_ack = 1'b1;
        tick();
        vec_cnt++;
        if (m_req !== 1'b0 || m_we !== 1'b0 || busy !== 1'b1 || db !== 8'h00) begin
            err_cnt++;
            $display("FAIL write_ack: m_req=%b m_we=%b busy=%b db=%h need 0 0 1 00", m_req, m_we, busy, db);
        end
        m_ack = 1'b0;
        tick();
        #1;
        // DR keeps the previous read value because a write never loads it.
        vec_cnt++;
        if (busy !== 1'b0 || db !== 8'hA5) begin
            err_cnt++;
            $display("FAIL write_done: busy=%b db=%h need 0 a5", busy, db);
        end
        db_mem = 1'b0;
    endtask

    task automatic test_timeout();
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++;
            if (m_req !== 1'b1 || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL timeout_wait%0d: m_req=%b busy=%b need 1 1", i, m_req, busy);
            end
        end
        tick();
        db_mem = 1'b1;
        #1;
        vec_cnt++;
        if (m_req !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || db !== 8'hFF) begin
            err_cnt++;
            $display("FAIL timeout_abort: m_req=%b busy=%b err=%b db=%h need 0 0 1 ff", m_req, busy, err, db);
        end
        db_mem = 1'b0;
        err_clr = 1'b1;
        tick();
        vec_cnt++;
        if (err !== 1'b0) begin
            err_cnt++;
            $display("FAIL err_clr: err=%b need 0", err);
        end
        mem_rd = 1'b1; mem_wr = 1'b1;
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0;
        vec_cnt++;
        if (err !== 1'b1 || m_req !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL err_set_wins: err=%b m_req=%b busy=%b need 1 0 0", err, m_req, busy);
        end
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_illegal();
        mem_rd = 1'b1; mem_wr = 1'b1;
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0;
        vec_cnt++;
        if (m_req !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
            err_cnt++;
            $display("FAIL illegal_cmd: m_req=%b busy=%b err=%b need 0 0 1", m_req, busy, err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        abl = 8'h55; adl_load = 1'b1;
        tick();
        adl_load = 1'b0;
        db_mem = 1'b1;
        #1;
        vec_cnt++;
        if (addr !== 16'h80FF || db !== 8'h00) begin
            err_cnt++;
            $display("FAIL load_in_req: addr=%h db=%h need 80ff 00", addr, db);
        end
        db_mem = 1'b0;
        mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0;
        vec_cnt++;
        if (err !== 1'b0 || m_we !== 1'b0 || m_req !== 1'b1) begin
            err_cnt++;
            $display("FAIL cmd_in_req: err=%b m_we=%b m_req=%b need 0 0 1", err, m_we, m_req);
        end
        m_ack = 1'b1; mdi = 8'h5A;
        tick();
        m_ack = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h3E);
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        m_ack = 1'b1; mdi = exp_q[0];
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++;
            if (busy !== 1'b1 || m_req !== 1'b0) begin
                err_cnt++;
                $display("FAIL release_hold%0d: busy=%b m_req=%b need 1 0", i, busy, m_req);
            end
        end
        m_ack = 1'b0;
        tick();
        db_mem = 1'b1;
        #1;
        vec_cnt++;
        if (busy !== 1'b0 || db !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL release_idle: busy=%b db=%h need 0 %h", busy, db, exp_q[0]);
        end
        void'(exp_q.pop_front());
        db_mem = 1'b0;
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        vec_cnt++;
        if (m_req !== 1'b1 || m_we !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_req: m_req=%b m_we=%b need 1 0", m_req, m_we);
        end
        m_ack = 1'b1; mdi = exp_q[0];
        tick();
        m_ack = 1'b0;
        tick();
        db_mem = 1'b1;
        #1;
        vec_cnt++;
        if (busy !== 1'b0 || db !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL b2b_data: busy=%b db=%h need 0 %h", busy, db, exp_q[0]);
        end
        void'(exp_q.pop_front());
        db_mem = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        mem_rd = 1'b1; mem_wr = 1'b1;
        tick();
        mem_rd = 1'b0; mem_wr = 1'b0;
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        vec_cnt++;
        if (m_req !== 1'b1 || err !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset: m_req=%b err=%b need 1 1", m_req, err);
        end
        #2;
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (m_req !== 1'b0 || busy !== 1'b0 || m_we !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset: m_req=%b busy=%b m_we=%b need 0 0 0", m_req, busy, m_we);
        end
        db_mem = 1'b1;
        #1;
        vec_cnt++;
        if (addr !== 16'h0000 || db !== 8'h00 || err !== 1'b0 || mdo !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_clear: addr=%h db=%h err=%b mdo=%h need 0000 00 0 00", addr, db, err, mdo);
        end
        db_mem = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        abl = '0; abh = '0; adl_load = 1'b0; adh_load = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; db_mem = 1'b0; err_clr = 1'b0;
        mdi = '0; m_ack = 1'b0; tb_db = '0; tb_db_en = 1'b0;
        test_reset();
        test_addr_read();
        test_write();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
